// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and helpers for the fetch/prefetch unit.
package fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int PC_INCREMENT = 4;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    localparam int DEFAULT_QUEUE_DEPTH = 4;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    // Width of a counter that must represent the values 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int QUEUE_COUNT_WIDTH = count_width(DEFAULT_QUEUE_DEPTH);
    localparam int OUTSTANDING_WIDTH = count_width(DEFAULT_MAX_OUTSTANDING);

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Memory-port, redirect and decode-side handshake bundle of the fetch unit.
interface fetch_prefetch_unit_if import fetch_pkg::*; #(
    parameter int XLEN = 32
);

    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [XLEN-1:0]              mem_req_address;
    logic                         mem_resp_valid;
    logic [INSTRUCTION_WIDTH-1:0] mem_resp_data;
    logic                         jump_branch_enable;
    logic [XLEN-1:0]              jump_branch_address;
    logic                         decode_valid;
    logic                         decode_ready;
    logic [INSTRUCTION_WIDTH-1:0] decode_instruction;
    logic [XLEN-1:0]              decode_PC;

    modport master (
        output mem_req_valid,
        output mem_req_address,
        output decode_valid,
        output decode_instruction,
        output decode_PC,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  jump_branch_enable,
        input  jump_branch_address,
        input  decode_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_address,
        input  decode_valid,
        input  decode_instruction,
        input  decode_PC,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        output jump_branch_enable,
        output jump_branch_address,
        output decode_ready
    );

endinterface

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous instruction FIFO with flush; storage resets to zero so the head reads 0 after reset.
module instruction_queue import fetch_pkg::*; #(
    parameter int DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int WIDTH = INSTRUCTION_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [WIDTH-1:0]              head_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for storage, pointers and fill count; a full queue may push while popping.
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != FULL_COUNT) || do_pop_s);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a decoupled prefetch queue, credit-limited issue and redirect flush.
// Optional perf counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_prefetch_unit import fetch_pkg::*; #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_ADDRESS   = '0,
    parameter int              QUEUE_DEPTH     = DEFAULT_QUEUE_DEPTH,
    parameter int              MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                  CLK,
    input  logic                  reset,
    fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    localparam int OUT_W = count_width(MAX_OUTSTANDING);
    localparam int CNT_W = count_width(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INCREMENT);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]              fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]              head_pc_q, head_pc_d;
    logic [OUT_W-1:0]             outstanding_q, outstanding_d;
    logic [OUT_W-1:0]             drop_count_q, drop_count_d;
    logic [CNT_W-1:0]             occupancy_s;
    logic [INSTRUCTION_WIDTH-1:0] head_data_s;
    logic                         queue_full_s;
    logic                         queue_empty_s;
    logic                         credit_s;
    logic                         req_valid_s;
    logic                         accept_s;
    logic                         decode_valid_s;
    logic                         pop_s;
    logic                         push_s;
    logic [XLEN-1:0]              target_s;

    // Issue credit counts in-flight requests against free queue slots so every live response lands.
    always_comb begin
        credit_s = (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                   ((32'(outstanding_q) + 32'(occupancy_s)) < 32'(QUEUE_DEPTH));
        req_valid_s    = !reset && !bus.jump_branch_enable && credit_s;
        accept_s       = req_valid_s && bus.mem_req_ready;
        decode_valid_s = !queue_empty_s && !bus.jump_branch_enable;
        pop_s          = decode_valid_s && bus.decode_ready;
        target_s       = bus.jump_branch_address & ALIGN_MASK;
    end

    // PC tracking, outstanding count and stale-response drop accounting.
    always_comb begin
        outstanding_d = outstanding_q + OUT_W'(accept_s) - OUT_W'(bus.mem_resp_valid);
        if (bus.jump_branch_enable) begin
            fetch_pc_d   = target_s;
            head_pc_d    = target_s;
            drop_count_d = outstanding_q - OUT_W'(bus.mem_resp_valid);
            push_s       = 1'b0;
        end else begin
            fetch_pc_d = accept_s ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
            head_pc_d  = pop_s ? (head_pc_q + PC_STEP) : head_pc_q;
            if (bus.mem_resp_valid && (drop_count_q != '0)) begin
                drop_count_d = drop_count_q - OUT_W'(1);
                push_s       = 1'b0;
            end else begin
                drop_count_d = drop_count_q;
                push_s       = bus.mem_resp_valid && (!queue_full_s || pop_s);
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_ADDRESS;
            head_pc_q     <= RESET_ADDRESS;
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
        end
    end

    instruction_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (INSTRUCTION_WIDTH)
    ) u_queue (
        .clk       (CLK),
        .rst       (reset),
        .push      (push_s),
        .push_data (bus.mem_resp_data),
        .pop       (pop_s),
        .flush     (bus.jump_branch_enable),
        .head_data (head_data_s),
        .full      (queue_full_s),
        .empty     (queue_empty_s),
        .count     (occupancy_s)
    );

    assign bus.mem_req_valid      = req_valid_s;
    assign bus.mem_req_address    = fetch_pc_q;
    assign bus.decode_valid       = decode_valid_s;
    assign bus.decode_instruction = head_data_s;
    assign bus.decode_PC          = head_pc_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating stall and redirect counters.
    always_comb begin
        if (!decode_valid_s && !bus.jump_branch_enable && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (bus.jump_branch_enable && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign perf_stall_cycles = stall_cycles_q;
    assign perf_flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit against an epoch-tagged request/queue reference model.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;
    localparam int          QD       = 4;
    localparam int          MO       = 4;

    logic clk;
    logic reset;

    fetch_prefetch_unit_if #(.XLEN(XLEN)) bif ();

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    fetch_prefetch_unit #(
        .XLEN            (XLEN),
        .RESET_ADDRESS   (RST_ADDR),
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bif)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A request in flight: its address, the redirect epoch it belongs to, and when memory answers.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [31:0] model_q[$];
    logic [31:0] accept_log[$];
    logic [31:0] decode_log[$];
    logic [31:0] next_fetch;
    int          epoch;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          vectors;
    int          errors;
    int          exp_stall;
    int          exp_flush;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic clear_logs();
        accept_log.delete();
        decode_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bif.mem_resp_valid      = 1'b0;
        bif.jump_branch_enable  = 1'b0;
        bif.mem_req_ready       = 1'b0;
        bif.decode_ready        = 1'b0;
        inflight.delete();
        model_q.delete();
        clear_logs();
        next_fetch = RST_ADDR;
        epoch++;
        exp_stall = 0;
        exp_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus, checks at the falling edge, then reference-model update.
    task automatic run_cycle(input logic jb, input logic [31:0] jb_addr,
                             input logic mready, input logic dready);
        logic resp;
        logic exp_req;
        logic exp_dv;
        req_t r;
        bif.jump_branch_enable  = jb;
        bif.jump_branch_address = jb_addr;
        bif.mem_req_ready       = mready;
        bif.decode_ready        = dready;
        resp = 1'b0;
        if (inflight.size() > 0) begin
            resp = (inflight[0].due <= cyc);
        end
        bif.mem_resp_valid = resp;
        if (resp) bif.mem_resp_data = mem_data(inflight[0].addr);
        else      bif.mem_resp_data = $urandom();
        @(negedge clk);
        exp_req = !jb && (inflight.size() < MO) && ((inflight.size() + model_q.size()) < QD);
        exp_dv  = !jb && (model_q.size() > 0);
        vectors++;
        if (bif.mem_req_valid !== exp_req) begin
            errors++;
            $display("FAIL mem_req_valid cyc=%0d got=%b exp=%b", cyc, bif.mem_req_valid, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (bif.mem_req_address !== next_fetch) begin
                errors++;
                $display("FAIL mem_req_address cyc=%0d got=%h exp=%h", cyc, bif.mem_req_address, next_fetch);
            end
        end
        vectors++;
        if (bif.decode_valid !== exp_dv) begin
            errors++;
            $display("FAIL decode_valid cyc=%0d got=%b exp=%b", cyc, bif.decode_valid, exp_dv);
        end
        if (exp_dv) begin
            vectors++;
            if (bif.decode_PC !== model_q[0]) begin
                errors++;
                $display("FAIL decode_PC cyc=%0d got=%h exp=%h", cyc, bif.decode_PC, model_q[0]);
            end
            vectors++;
            if (bif.decode_instruction !== mem_data(model_q[0])) begin
                errors++;
                $display("FAIL decode_instruction cyc=%0d got=%h exp=%h", cyc,
                         bif.decode_instruction, mem_data(model_q[0]));
            end
        end
        if (!exp_dv && !jb) exp_stall++;
        if (jb) begin
            exp_flush++;
            epoch++;
            model_q.delete();
            next_fetch = jb_addr & 32'hFFFF_FFFC;
            if (resp) r = inflight.pop_front();
        end else begin
            if (exp_dv && dready) begin
                decode_log.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (resp) begin
                r = inflight.pop_front();
                if (r.epoch == epoch) model_q.push_back(r.addr);
            end
            if (exp_req && mready) begin
                accept_log.push_back(next_fetch);
                inflight.push_back('{addr: next_fetch, epoch: epoch,
                                     due: cyc + int'($urandom_range(lat_max, lat_min))});
                next_fetch = next_fetch + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bif.mem_resp_valid     = 1'b0;
        bif.mem_resp_data      = 32'h0;
        bif.jump_branch_enable = 1'b0;
        bif.jump_branch_address = 32'h0;
        bif.mem_req_ready      = 1'b0;
        bif.decode_ready       = 1'b0;
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (bif.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid got=%b exp=0", bif.mem_req_valid);
        end
        vectors++;
        if (bif.decode_valid !== 1'b0) begin
            errors++; $display("FAIL reset_decode_valid got=%b exp=0", bif.decode_valid);
        end
        vectors++;
        if (bif.decode_instruction !== 32'h0) begin
            errors++; $display("FAIL reset_decode_instruction got=%h exp=0", bif.decode_instruction);
        end
        vectors++;
        if (bif.decode_PC !== RST_ADDR) begin
            errors++; $display("FAIL reset_decode_PC got=%h exp=%h", bif.decode_PC, RST_ADDR);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (accept_log.size() <= i || accept_log[i] !== RST_ADDR + 32'(4 * i)) begin
                errors++; $display("FAIL seq_request_addr idx=%0d exp=%h", i, RST_ADDR + 32'(4 * i));
            end
        end
        vectors++;
        if (decode_log.size() == 0 || decode_log[0] !== RST_ADDR) begin
            errors++; $display("FAIL seq_first_decode got_count=%0d exp_pc=%h", decode_log.size(), RST_ADDR);
        end
    endtask

    task automatic test_fill();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (accept_log.size() != 4) begin
            errors++; $display("FAIL fill_requests got=%0d exp=4", accept_log.size());
        end
        run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (accept_log.size() != 5) begin
            errors++; $display("FAIL fill_after_pop got=%0d exp=5", accept_log.size());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        clear_logs();
        run_cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        vectors++;
        if (accept_log.size() == 0 || accept_log[0] !== 32'h0000_0100) begin
            errors++; $display("FAIL redirect_first_request count=%0d exp=00000100", accept_log.size());
        end
        vectors++;
        if (decode_log.size() == 0 || decode_log[0] !== 32'h0000_0100) begin
            errors++; $display("FAIL redirect_first_decode count=%0d exp=00000100", decode_log.size());
        end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        clear_logs();
        run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        vectors++;
        if (decode_log.size() == 0 || decode_log[0] !== 32'h0000_0200) begin
            errors++; $display("FAIL coincident_first_decode count=%0d exp=00000200", decode_log.size());
        end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        clear_logs();
        run_cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        vectors++;
        if (accept_log.size() < 2 || accept_log[0] !== 32'hFFFF_FFFC || accept_log[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_requests count=%0d exp=fffffffc,00000000", accept_log.size());
        end
        vectors++;
        if (decode_log.size() < 2 || decode_log[0] !== 32'hFFFF_FFFC || decode_log[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_decode count=%0d exp=fffffffc,00000000", decode_log.size());
        end
    endtask

    task automatic test_random();
        logic jb;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            jb = ($urandom_range(24, 0) == 0);
            run_cycle(jb, $urandom(), ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
        end
`ifdef FETCH_PERF_COUNTERS_EN
        vectors++;
        if (perf_stall_cycles !== 32'(exp_stall)) begin
            errors++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_cycles, exp_stall);
        end
        vectors++;
        if (perf_flush_count !== 32'(exp_flush)) begin
            errors++; $display("FAIL perf_flush got=%0d exp=%0d", perf_flush_count, exp_flush);
        end
`endif
    endtask

    task automatic test_async_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        bif.mem_resp_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bif.mem_req_valid !== 1'b0 || bif.decode_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_valids got=%b%b exp=00", bif.mem_req_valid, bif.decode_valid);
        end
        vectors++;
        if (bif.decode_PC !== RST_ADDR || bif.decode_instruction !== 32'h0) begin
            errors++; $display("FAIL async_reset_decode got=%h/%h exp=%h/00000000",
                               bif.decode_PC, bif.decode_instruction, RST_ADDR);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        vectors++;
        if (perf_stall_cycles !== 32'h0 || perf_flush_count !== 32'h0) begin
            errors++; $display("FAIL async_reset_perf got=%0d/%0d exp=0/0", perf_stall_cycles, perf_flush_count);
        end
`endif
        do_reset();
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        vectors++;
        if (accept_log.size() == 0 || accept_log[0] !== RST_ADDR) begin
            errors++; $display("FAIL async_reset_restart count=%0d exp=%h", accept_log.size(), RST_ADDR);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        epoch   = 0;
        cyc     = 0;
        lat_min = 1;
        lat_max = 1;
        test_reset();
        test_sequential();
        test_fill();
        test_redirect();
        test_redirect_coincident();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised fetch stage with a decoupled instruction prefetch queue, sitting between the instruction memory port and the decode pipeline register.
- Issues sequential word fetches ahead of decode, up to QUEUE_DEPTH outstanding requests plus buffered entries.
- Presents instruction/PC pairs to decode with a valid/ready handshake.
- Flushes and redirects on jump/branch, discarding stale in-flight responses.

Parameters:
- RESET_ADDRESS, 32'h00000000: first fetch address after reset.
- XLEN, 32: PC/address width.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, minimum 2.
- MAX_OUTSTANDING, 4: maximum in-flight memory requests; must be <= QUEUE_DEPTH.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_req_address  output  XLEN  word-aligned fetch address.
- mem_resp_valid  input  1  response data valid; in order; cannot be back-pressured.
- mem_resp_data  input  32  fetched instruction.
- jump_branch_enable  input  1  single-cycle redirect strobe.
- jump_branch_address  input  XLEN  redirect target.
- decode_valid  output  1  queue head is valid.
- decode_ready  input  1  decode consumes the head this cycle.
- decode_instruction  output  32  head instruction.
- decode_PC  output  XLEN  PC of the head instruction.

Behaviour:
Reset values:
- fetch_PC = head_PC = RESET_ADDRESS.
- Queue empty; outstanding = 0; drop_count = 0.
- mem_req_valid = 0, decode_valid = 0, decode_instruction = 0, decode_PC = RESET_ADDRESS.

Request issue:
- mem_req_valid = !reset && !jump_branch_enable && (outstanding < MAX_OUTSTANDING) && (outstanding + occupancy < QUEUE_DEPTH).
- Under this credit rule every live response is guaranteed a queue slot.
- mem_req_address = fetch_PC. On valid&&ready, fetch_PC += 4 (wraps modulo 2^XLEN) and outstanding increments.

Response handling:
- When mem_resp_valid is high, outstanding decrements.
- If drop_count > 0, the data is discarded and drop_count decrements; otherwise the data is pushed to the queue tail.
- Accept and response in the same cycle leaves outstanding unchanged.

Decode side:
- decode_valid = queue not empty. decode_instruction is the head entry; decode_PC = head_PC, held in a register.
- On decode_valid && decode_ready: pop the head; head_PC += 4.
- Push and pop in the same cycle: occupancy unchanged; a full queue pushing while popping is legal.
- Latency: a response accepted in cycle t becomes visible on decode in cycle t+1 (registered, no bypass).

Redirect (jump_branch_enable = 1 in cycle t):
- Target is jump_branch_address with bits [1:0] forced to 0.
- fetch_PC and head_PC load the target.
- Queue flushed; any pop in cycle t is ignored (decode_valid is forced 0 in cycle t).
- mem_req_valid is suppressed in cycle t, so no new request is accepted.
- drop_count <= outstanding - (mem_resp_valid ? 1 : 0). Any response arriving in cycle t is discarded.
- First request to the target is issued in cycle t+1.
- Back-to-back redirects: the last one wins; drop_count is recomputed each time.

Reset mid-operation:
- All state clears immediately.
- The memory system shares this reset, so no responses arrive for pre-reset requests.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both reset to 0 and saturating at all-ones.
  - perf_stall_cycles increments each cycle with decode_valid=0 and jump_branch_enable=0.
  - perf_flush_count increments on each redirect.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - INSTRUCTION_WIDTH = 32.
  - PC_INCREMENT = 4.
  - NOP_INSTRUCTION = 32'h00000013.
  - Counter-width constants derived from QUEUE_DEPTH and MAX_OUTSTANDING ($clog2(N+1)).
- Sub-module instruction_queue: synchronous FIFO (push, pop, flush, full, empty, count; QUEUE_DEPTH x 32) with an asynchronous reset.
- PC tracking, credit and drop logic stay in the top level.

Test Plan:
1. Reset release, mem_req_ready=1, 1-cycle memory, decode_ready=1:
   - requests at 0x0, 0x4, 0x8, …
   - decode sees PC 0x0 with its data one cycle after the response, then one instruction per cycle.
2. decode_ready=0, memory always ready:
   - exactly 4 requests issued, queue fills to 4, mem_req_valid then stays 0.
   - after one pop, exactly one further request is issued.
3. 3 requests outstanding, redirect to 0x103:
   - next request at 0x100.
   - the 3 stale responses are discarded; the first decode_PC is 0x100 with the new-stream data.
4. Redirect coincident with a response and a decode pop:
   - response dropped, pop ignored, decode_valid=0 in that cycle.
   - drop_count = outstanding-1.
5. Redirect to 0xFFFFFFFC:
   - fetches 0xFFFFFFFC then 0x00000000; decode_PC wraps identically.
6. Assert reset asynchronously mid-burst:
   - outputs return to their reset values without a clock edge.
   - fetching restarts at RESET_ADDRESS; with FETCH_PERF_COUNTERS_EN, the counters read 0.
